// File: rtl/imemory_stage_pkg.sv
// Shared definitions for the LEGv8 memory-access stage: datapath width,
// data-memory default depth, the EX/MEM register layout and the existing
// LEGv8 opcode / ALUOp encodings used across the pipeline.
`ifndef WORD
`define WORD 64
`endif

package imemory_stage_pkg;

   localparam int WORD           = `WORD;
   localparam int DMEM_DEPTH_DEF = 64;

   // LEGv8 R/D-format opcodes (11-bit major opcode field)
   typedef enum logic [10:0] {
      OP_ADD  = 11'h458,
      OP_SUB  = 11'h658,
      OP_AND  = 11'h450,
      OP_ORR  = 11'h550,
      OP_LDUR = 11'h7C2,
      OP_STUR = 11'h7C0
   } legv8_op_e;

   // Main-decoder ALUOp field
   typedef enum logic [1:0] {
      ALUOP_MEM   = 2'b00,
      ALUOP_CBZ   = 2'b01,
      ALUOP_RTYPE = 2'b10
   } alu_op_e;

   // EX/MEM pipeline register fields
   typedef struct packed {
      logic            valid;
      logic            mem_read;
      logic            mem_write;
      logic            mem_to_reg;
      logic            reg_write;
      logic            branch;
      logic            uncond_branch;
      logic            zero;
      logic [4:0]      write_reg;
      logic [WORD-1:0] branch_target;
      logic [WORD-1:0] alu_result;
      logic [WORD-1:0] read_data2;
   } ex_mem_t;

   // Branch decision for a registered instruction
   function automatic logic take_branch(input ex_mem_t r);
      return r.valid & (r.uncond_branch | (r.branch & r.zero));
   endfunction

endpackage

// File: rtl/imemory_stage_if.sv
// Execute-to-memory bus: execute results and control in, registered
// results, load data and branch decision out.
// Optional: MEM_ALIGN_CHECK_EN adds the misaligned flag.
interface imemory_stage_if;
   import imemory_stage_pkg::*;

   // execute side
   logic            stall;
   logic            flush;
   logic            ex_valid;
   logic [WORD-1:0] branch_target;
   logic [WORD-1:0] alu_result;
   logic            zero;
   logic [WORD-1:0] read_data2;
   logic            mem_read;
   logic            mem_write;
   logic            mem_to_reg;
   logic            reg_write;
   logic            branch;
   logic            uncond_branch;
   logic [4:0]      write_reg;

   // memory-stage results
   logic            pc_src;
   logic [WORD-1:0] branch_target_out;
   logic [WORD-1:0] mem_read_data;
   logic [WORD-1:0] alu_result_out;
   logic [4:0]      write_reg_out;
   logic            reg_write_out;
   logic            mem_to_reg_out;
   logic            valid_out;
`ifdef MEM_ALIGN_CHECK_EN
   logic            misaligned;
`endif

   modport master (
      output stall, flush, ex_valid, branch_target, alu_result, zero,
             read_data2, mem_read, mem_write, mem_to_reg, reg_write,
             branch, uncond_branch, write_reg,
      input  pc_src, branch_target_out, mem_read_data, alu_result_out,
             write_reg_out, reg_write_out, mem_to_reg_out, valid_out
`ifdef MEM_ALIGN_CHECK_EN
      , input misaligned
`endif
   );

   modport slave (
      input  stall, flush, ex_valid, branch_target, alu_result, zero,
             read_data2, mem_read, mem_write, mem_to_reg, reg_write,
             branch, uncond_branch, write_reg,
      output pc_src, branch_target_out, mem_read_data, alu_result_out,
             write_reg_out, reg_write_out, mem_to_reg_out, valid_out
`ifdef MEM_ALIGN_CHECK_EN
      , output misaligned
`endif
   );

endinterface

// File: rtl/imemory_stage_data_memory.sv
// Data memory for the memory-access stage: DEPTH x WORD array with a
// synchronous write port, a combinational read port and a full clear on reset.
module data_memory
   import imemory_stage_pkg::*;
#(
   parameter int DEPTH     = DMEM_DEPTH_DEF,
   parameter int ADDR_BITS = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_we,
   input  logic [ADDR_BITS-1:0] i_addr,
   input  logic [WORD-1:0]      i_wdata,
   output logic [WORD-1:0]      o_rdata
);

   logic [WORD-1:0] r_mem [DEPTH];

   // Clear on reset, otherwise perform the requested write
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: clearing every entry on reset is architecturally required here;
         // it keeps this array in flops rather than a RAM macro.
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/imemory_stage.sv
// LEGv8 memory-access stage: EX/MEM pipeline register with stall/flush,
// data memory, branch resolution (pc_src) and write-back pass-through.
// Optional: define MEM_ALIGN_CHECK_EN to flag and suppress accesses whose
// byte address is not 8-byte aligned (adds the misaligned output).
module imemory_stage
   import imemory_stage_pkg::*;
#(
   parameter int DMEM_DEPTH = DMEM_DEPTH_DEF,
   parameter int ADDR_BITS  = $clog2(DMEM_DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   imemory_stage_if.slave bus
);

   ex_mem_t                r_ex_mem;
   ex_mem_t                w_ex_in;
   logic                   r_wr_done;
   logic                   w_align_ok;
   logic                   w_we;
   logic                   w_rd_en;
   logic [ADDR_BITS-1:0]   w_addr;
   logic [WORD-1:0]        w_rdata;

   // Assemble the incoming execute results into the register layout
   always_comb begin
      // NOTE: default the whole struct first so no field can hold its old
      // value through a path and infer a latch.
      w_ex_in               = '0;
      w_ex_in.valid         = bus.ex_valid;
      w_ex_in.mem_read      = bus.mem_read;
      w_ex_in.mem_write     = bus.mem_write;
      w_ex_in.mem_to_reg    = bus.mem_to_reg;
      w_ex_in.reg_write     = bus.reg_write;
      w_ex_in.branch        = bus.branch;
      w_ex_in.uncond_branch = bus.uncond_branch;
      w_ex_in.zero          = bus.zero;
      w_ex_in.write_reg     = bus.write_reg;
      w_ex_in.branch_target = bus.branch_target;
      w_ex_in.alu_result    = bus.alu_result;
      w_ex_in.read_data2    = bus.read_data2;
   end

   // EX/MEM register: reset > flush > stall > load
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, independent of statement order.
      if (rst)             r_ex_mem <= '0;
      else if (bus.flush)  r_ex_mem <= '0;
      else if (!bus.stall) r_ex_mem <= w_ex_in;
   end

   // One-shot store flag: set once the held store has written, cleared
   // whenever a new instruction (or bubble) enters the stage
   always_ff @(posedge clk) begin
      if (rst)                         r_wr_done <= 1'b0;
      else if (bus.flush || !bus.stall) r_wr_done <= 1'b0;
      else if (w_we)                   r_wr_done <= 1'b1;
   end

`ifdef MEM_ALIGN_CHECK_EN
   logic w_misaligned;
   assign w_misaligned   = r_ex_mem.valid & (r_ex_mem.mem_read | r_ex_mem.mem_write)
                           & (r_ex_mem.alu_result[2:0] != 3'b000);
   assign w_align_ok     = ~w_misaligned;
   assign bus.misaligned = w_misaligned;
`else
   assign w_align_ok     = 1'b1;
`endif

   // Word index: byte offset dropped, upper bits wrap modulo the array size
   assign w_addr  = r_ex_mem.alu_result[ADDR_BITS+2:3];
   assign w_we    = r_ex_mem.valid & r_ex_mem.mem_write & ~r_wr_done & w_align_ok;
   assign w_rd_en = r_ex_mem.valid & r_ex_mem.mem_read & w_align_ok;

   data_memory #(
      .DEPTH     (DMEM_DEPTH),
      .ADDR_BITS (ADDR_BITS)
   ) u_dmem (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_we),
      .i_addr  (w_addr),
      .i_wdata (r_ex_mem.read_data2),
      .o_rdata (w_rdata)
   );

   assign bus.mem_read_data     = w_rd_en ? w_rdata : '0;
   assign bus.pc_src            = take_branch(r_ex_mem);
   assign bus.branch_target_out = r_ex_mem.branch_target;
   assign bus.alu_result_out    = r_ex_mem.alu_result;
   assign bus.write_reg_out     = r_ex_mem.write_reg;
   assign bus.reg_write_out     = r_ex_mem.reg_write;
   assign bus.mem_to_reg_out    = r_ex_mem.mem_to_reg;
   assign bus.valid_out         = r_ex_mem.valid;

endmodule

// File: tb/tb_imemory_stage.sv
// Scoreboard bench for imemory_stage: a driver applies one instruction per
// cycle and pushes the expected post-edge outputs from a behavioural model;
// a monitor pops and compares after every rising edge.
`timescale 1ns/1ps
module tb_imemory_stage;
   import imemory_stage_pkg::*;

   localparam int DEPTH = 64;

   typedef struct packed {
      logic            rst, stall, flush, ex_valid, zero;
      logic            mem_read, mem_write, mem_to_reg, reg_write, branch, uncond;
      logic [4:0]      wreg;
      logic [WORD-1:0] target, alu, data;
   } stim_t;

   typedef struct packed {
      logic            pc_src, valid, reg_write, mem_to_reg, mis;
      logic [4:0]      wreg;
      logic [WORD-1:0] target, rdata, alu;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   imemory_stage_if bus ();

   imemory_stage #(.DMEM_DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int   n_checks = 0;
   int   n_errors = 0;
   int   cycle    = 0;
   exp_t exp_q[$];

   // reference model: what the stage holds and what memory contains
   stim_t           stage;
   logic [WORD-1:0] mem_m [DEPTH];

   task automatic check(input string name, input logic [WORD-1:0] act, input logic [WORD-1:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s (cycle %0d): got %h, expected %h", name, cycle, act, req);
      end
   endtask

   function automatic int word_of(input logic [WORD-1:0] byte_addr);
      return int'((byte_addr / 8) % DEPTH);
   endfunction

   function automatic logic is_mis(input stim_t s);
`ifdef MEM_ALIGN_CHECK_EN
      return s.ex_valid && (s.mem_read || s.mem_write) && (s.alu % 8 != 0);
`else
      return 1'b0;
`endif
   endfunction

   // one clock edge of the stage, computed from the behavioural rules
   function automatic exp_t model_edge(input stim_t s);
      exp_t e;
      if (!s.rst && stage.ex_valid && stage.mem_write && !is_mis(stage))
         mem_m[word_of(stage.alu)] = stage.data;
      if (s.rst) begin
         for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
         stage = '0;
      end else if (s.flush) begin
         stage = '0;
      end else if (!s.stall) begin
         stage = s;
      end
      e            = '0;
      e.valid      = stage.ex_valid;
      e.pc_src     = stage.ex_valid && (stage.uncond || (stage.branch && stage.zero));
      e.reg_write  = stage.reg_write;
      e.mem_to_reg = stage.mem_to_reg;
      e.wreg       = stage.wreg;
      e.target     = stage.target;
      e.alu        = stage.alu;
      e.mis        = is_mis(stage);
      e.rdata      = (stage.ex_valid && stage.mem_read && !e.mis) ? mem_m[word_of(stage.alu)] : '0;
      return e;
   endfunction

   // instruction builders
   function automatic stim_t nop();
      stim_t s = '0;
      return s;
   endfunction
   function automatic stim_t stur(input logic [WORD-1:0] a, input logic [WORD-1:0] d);
      stim_t s = '0;
      s.ex_valid = 1'b1; s.mem_write = 1'b1; s.alu = a; s.data = d;
      s.wreg = 5'($urandom); s.target = WORD'($urandom);
      return s;
   endfunction
   function automatic stim_t ldur(input logic [WORD-1:0] a, input logic [4:0] r);
      stim_t s = '0;
      s.ex_valid = 1'b1; s.mem_read = 1'b1; s.mem_to_reg = 1'b1; s.reg_write = 1'b1;
      s.alu = a; s.wreg = r; s.data = WORD'($urandom);
      return s;
   endfunction
   function automatic stim_t cbz(input logic [WORD-1:0] t, input logic z);
      stim_t s = '0;
      s.ex_valid = 1'b1; s.branch = 1'b1; s.zero = z; s.target = t; s.alu = WORD'($urandom);
      return s;
   endfunction
   function automatic stim_t b_uncond(input logic [WORD-1:0] t, input logic z);
      stim_t s = '0;
      s.ex_valid = 1'b1; s.uncond = 1'b1; s.zero = z; s.target = t;
      return s;
   endfunction
   function automatic stim_t add(input logic [WORD-1:0] r, input logic [4:0] d);
      stim_t s = '0;
      s.ex_valid = 1'b1; s.reg_write = 1'b1; s.alu = r; s.wreg = d;
      s.zero = (r == 0); s.data = WORD'($urandom);
      return s;
   endfunction

   task automatic drive(input stim_t s);
      @(negedge clk);
      rst               = s.rst;
      bus.stall         = s.stall;
      bus.flush         = s.flush;
      bus.ex_valid      = s.ex_valid;
      bus.zero          = s.zero;
      bus.mem_read      = s.mem_read;
      bus.mem_write     = s.mem_write;
      bus.mem_to_reg    = s.mem_to_reg;
      bus.reg_write     = s.reg_write;
      bus.branch        = s.branch;
      bus.uncond_branch = s.uncond;
      bus.write_reg     = s.wreg;
      bus.branch_target = s.target;
      bus.alu_result    = s.alu;
      bus.read_data2    = s.data;
      exp_q.push_back(model_edge(s));
   endtask

   // monitor: compare the stage outputs after every edge that has an expectation
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         cycle++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("valid_out",         WORD'(bus.valid_out),      WORD'(e.valid));
            check("pc_src",            WORD'(bus.pc_src),         WORD'(e.pc_src));
            check("reg_write_out",     WORD'(bus.reg_write_out),  WORD'(e.reg_write));
            check("mem_to_reg_out",    WORD'(bus.mem_to_reg_out), WORD'(e.mem_to_reg));
            check("write_reg_out",     WORD'(bus.write_reg_out),  WORD'(e.wreg));
            check("branch_target_out", bus.branch_target_out,     e.target);
            check("alu_result_out",    bus.alu_result_out,        e.alu);
            check("mem_read_data",     bus.mem_read_data,         e.rdata);
`ifdef MEM_ALIGN_CHECK_EN
            check("misaligned",        WORD'(bus.misaligned),     WORD'(e.mis));
`endif
         end
      end
   end

   // watchdog
   initial begin
      #200us;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      stim_t s;
      stage = '0;
      for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;

      // reset, then a store that lands, then reset with stores pending
      s = nop(); s.rst = 1'b1;
      drive(s); drive(s);
      drive(stur(112, 77));
      drive(nop());
      s = stur(112, 99); s.rst = 1'b1;
      drive(s); drive(s);
      drive(ldur(112, 5'd1));
      drive(nop());

      // store then load to the same address on the next cycle
      drive(stur(112, 30));
      drive(ldur(112, 5'd2));

      // branch resolution
      drive(cbz(~WORD'(3), 1'b1));
      drive(cbz(~WORD'(3), 1'b0));
      drive(b_uncond(280, 1'b0));
      drive(b_uncond(280, 1'b1));

      // stall holds the register; flush with stall inserts a bubble
      drive(add(30, 5'd3));
      for (int i = 0; i < 3; i++) begin
         s = add(WORD'($urandom), 5'($urandom)); s.stall = 1'b1;
         drive(s);
      end
      s = b_uncond(64, 1'b1); s.reg_write = 1'b1; s.stall = 1'b1; s.flush = 1'b1;
      drive(s);

      // single store under stall
      drive(stur(80, 64'hAA));
      for (int i = 0; i < 2; i++) begin
         s = stur(80, 64'h55); s.stall = 1'b1;
         drive(s);
      end
      drive(ldur(80, 5'd4));

      // address wrap and low-bit handling
      drive(stur(512 + 16, 64'h1234_5678));
      drive(ldur(16, 5'd5));
      drive(stur(84, 64'hBEEF));
      drive(ldur(80, 5'd6));
      drive(ldur(84, 5'd7));
      drive(nop());

      // randomized traffic over a small address window
      for (int n = 0; n < 500; n++) begin
         logic [WORD-1:0] a;
         int op;
         a = WORD'($urandom_range(0, 7) * 8 + $urandom_range(0, 3) * DEPTH * 8);
         if ($urandom_range(0, 7) == 0) a = a + WORD'($urandom_range(1, 7));
         op = $urandom_range(0, 5);
         case (op)
            0: s = nop();
            1: s = add(WORD'({$urandom, $urandom}), 5'($urandom));
            2: s = stur(a, WORD'({$urandom, $urandom}));
            3: s = ldur(a, 5'($urandom));
            4: s = cbz(WORD'({$urandom, $urandom}), 1'($urandom));
            default: s = b_uncond(WORD'({$urandom, $urandom}), 1'($urandom));
         endcase
         if ($urandom_range(0, 9) == 0) s.ex_valid = 1'b0;
         s.stall = ($urandom_range(0, 4) == 0);
         s.flush = ($urandom_range(0, 9) == 0);
         s.rst   = ($urandom_range(0, 59) == 0);
         drive(s);
      end

      drive(nop());
      repeat (3) @(posedge clk);
      #2;
      check("scoreboard_drained", WORD'(exp_q.size()), '0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
